// File: rtl/lps_pkg.sv
// lps_pkg: shared constants, mode encodings and FSM state type for the light-pen matrix
package lps_pkg;

    localparam int ROWS_DEF      = 8;
    localparam int COLS_DEF      = 8;
    localparam int CH_DEF        = 2;
    localparam int DISP_CYC_DEF  = 4;
    localparam int PROBE_CYC_DEF = 4;

    localparam logic [1:0] MODE_DRAW   = 2'd0;
    localparam logic [1:0] MODE_ERASE  = 2'd1;
    localparam logic [1:0] MODE_FREEZE = 2'd2;

    typedef enum logic [1:0] {
        ST_DISP,
        ST_BLANK1,
        ST_PROBE,
        ST_BLANK2
    } state_e;

endpackage

// File: rtl/pen_sync.sv
// pen_sync: two-flop synchroniser for the asynchronous light-pen level
module pen_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/lightpen_matrix_ctrl.sv
// lightpen_matrix_ctrl: multiplexed LED matrix with a raster light-pen probe that draws/erases pixels
module lightpen_matrix_ctrl
    import lps_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int CH        = CH_DEF,
    parameter int DISP_CYC  = DISP_CYC_DEF,
    parameter int PROBE_CYC = PROBE_CYC_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pen_i,
    input  logic [1:0]                     mode_i,
    input  logic [CH-1:0]                  color_i,
    input  logic                           clr_i,
    output logic [ROWS-1:0]                row_o,
    output logic [CH*COLS-1:0]             col_o,
    output logic                           hit_o,
    output logic [$clog2(ROWS)-1:0]        hit_row_o,
    output logic [$clog2(COLS)-1:0]        hit_col_o,
    output logic [$clog2(ROWS*COLS+1)-1:0] lit_cnt_o
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = $clog2(ROWS*COLS+1);
    localparam int MC = DISP_CYC > PROBE_CYC ? DISP_CYC : PROBE_CYC;
    localparam int YW = MC > 1 ? $clog2(MC) : 1;
    localparam logic [YW-1:0] D_LAST = YW'(DISP_CYC-1);
    localparam logic [YW-1:0] P_LAST = YW'(PROBE_CYC-1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS-1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS-1);

    state_e                             st_q, st_d;
    logic [YW-1:0]                      cyc_q, cyc_d;
    logic [RW-1:0]                      r_q, r_d, pr_q, hr_q;
    logic [CW-1:0]                      c_q, c_d, pc_q, hc_q;
    logic [CH-1:0][ROWS-1:0][COLS-1:0]  fb_q, fb_d;
    logic [ROWS*COLS-1:0]               lit_map;
    logic [ROWS-1:0]                    row_q, row_d;
    logic [CH*COLS-1:0]                 col_q, col_d;
    logic [LW-1:0]                      lit_q, lit_d;
    logic                               last_q, hit_q, pen_s, hit, wr;

    pen_sync u_sync (.clk(clk), .rst(rst), .d_i(pen_i), .q_o(pen_s));

    // last_q/pr_q/pc_q describe the pixel currently on the outputs, one clock behind the counters
    assign hit = last_q & pen_s;
    assign wr  = hit & (mode_i == MODE_DRAW || mode_i == MODE_ERASE);

    always_comb begin
        st_d  = st_q;
        cyc_d = cyc_q + 1'b1;
        r_d   = r_q;
        c_d   = c_q;
        case (st_q)
            ST_DISP: if (cyc_q == D_LAST) begin
                cyc_d = '0;
                r_d   = r_q == R_LAST ? '0 : r_q + 1'b1;
                st_d  = r_q == R_LAST ? ST_BLANK1 : ST_DISP;
            end
            ST_PROBE: if (cyc_q == P_LAST) begin
                cyc_d = '0;
                c_d   = c_q == C_LAST ? '0 : c_q + 1'b1;
                if (c_q == C_LAST) begin
                    r_d  = r_q == R_LAST ? '0 : r_q + 1'b1;
                    st_d = r_q == R_LAST ? ST_BLANK2 : ST_PROBE;
                end
            end
            ST_BLANK1: begin
                cyc_d = '0;
                st_d  = ST_PROBE;
            end
            default: begin
                cyc_d = '0;
                st_d  = ST_DISP;
            end
        endcase
    end

    always_comb begin
        row_d = '0;
        col_d = '0;
        if (st_q == ST_DISP || st_q == ST_PROBE) row_d[r_q] = 1'b1;
        for (int k = 0; k < CH; k++) begin
            if (st_q == ST_DISP) col_d[k*COLS +: COLS] = fb_q[k][r_q];
            if (st_q == ST_PROBE) col_d[k*COLS + int'(c_q)] = 1'b1;
        end
    end

    always_comb begin
        fb_d    = fb_q;
        lit_map = '0;
        lit_d   = '0;
        for (int k = 0; k < CH; k++) begin
            if (wr) fb_d[k][pr_q][pc_q] = (mode_i == MODE_DRAW) & color_i[k];
            lit_map |= fb_q[k];
        end
        if (clr_i) fb_d = '0;
        for (int i = 0; i < ROWS*COLS; i++) lit_d = lit_d + LW'(lit_map[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_DISP;
            cyc_q  <= '0;
            r_q    <= '0;
            c_q    <= '0;
            pr_q   <= '0;
            pc_q   <= '0;
            last_q <= 1'b0;
            hit_q  <= 1'b0;
            hr_q   <= '0;
            hc_q   <= '0;
            fb_q   <= '0;
            lit_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            st_q   <= st_d;
            cyc_q  <= cyc_d;
            r_q    <= r_d;
            c_q    <= c_d;
            pr_q   <= r_q;
            pc_q   <= c_q;
            last_q <= st_q == ST_PROBE && cyc_q == P_LAST;
            hit_q  <= hit;
            if (hit) begin
                hr_q <= pr_q;
                hc_q <= pc_q;
            end
            fb_q   <= fb_d;
            lit_q  <= lit_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    assign row_o     = row_q;
    assign col_o     = col_q;
    assign hit_o     = hit_q;
    assign hit_row_o = hr_q;
    assign hit_col_o = hc_q;
    assign lit_cnt_o = lit_q;
endmodule

// File: tb/tb_lightpen_matrix_ctrl.sv
// tb_lightpen_matrix_ctrl: frame-position reference model, per-cycle compare, directed and random stimulus
module tb_lightpen_matrix_ctrl;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CH    = 2;
    localparam int DC    = 4;
    localparam int PC    = 4;
    localparam int FRAME = ROWS*DC + ROWS*COLS*PC + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pen_i = 1'b0;
    logic              clr_i = 1'b0;
    logic [1:0]        mode_i = 2'd0;
    logic [CH-1:0]     color_i = '0;
    logic [ROWS-1:0]   row_o;
    logic [CH*COLS-1:0] col_o;
    logic              hit_o;
    logic [2:0]        hit_row_o, hit_col_o;
    logic [6:0]        lit_cnt_o;

    int checks = 0;
    int fails  = 0;
    int tc     = 0;
    int hits   = 0;
    bit mon_en = 1'b0;

    lightpen_matrix_ctrl #(.ROWS(ROWS), .COLS(COLS), .CH(CH), .DISP_CYC(DC), .PROBE_CYC(PC)) dut (
        .clk(clk), .rst(rst), .pen_i(pen_i), .mode_i(mode_i), .color_i(color_i), .clr_i(clr_i),
        .row_o(row_o), .col_o(col_o), .hit_o(hit_o), .hit_row_o(hit_row_o),
        .hit_col_o(hit_col_o), .lit_cnt_o(lit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s actual=%0h required=%0h clock=%0d", nm, act, exp, tc);
        end
    endtask

    // Reference model: k clocks since reset release; clock m shows frame position m-1
    int                 k = 0;
    bit                 mb [CH][ROWS][COLS];
    bit                 penq [$];
    logic [ROWS-1:0]    e_row = '0;
    logic [CH*COLS-1:0] e_col = '0;
    logic               e_hit = 1'b0;
    logic [2:0]         e_hr = '0, e_hc = '0;
    logic [6:0]         e_lit = '0;

    function automatic int lit_count();
        int n;
        bit any;
        n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                any = 0;
                for (int h = 0; h < CH; h++) any |= mb[h][r][c];
                n += int'(any);
            end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        int fp, pix, hp;
        bit hit;
        if (rst) begin
            k = 0;
            penq.delete();
            foreach (mb[a, b, c]) mb[a][b][c] = 0;
            e_row = '0;
            e_col = '0;
            e_hit = 1'b0;
            e_hr  = '0;
            e_hc  = '0;
            e_lit = '0;
        end else begin
            k++;
            penq.push_back(pen_i);
            e_lit = 7'(lit_count());
            fp = (k - 1) % FRAME;
            e_row = '0;
            e_col = '0;
            if (fp < ROWS*DC) begin
                e_row[fp/DC] = 1'b1;
                for (int h = 0; h < CH; h++)
                    for (int c = 0; c < COLS; c++) e_col[h*COLS + c] = mb[h][fp/DC][c];
            end else if (fp > ROWS*DC && fp < FRAME - 1) begin
                pix = (fp - ROWS*DC - 1) / PC;
                e_row[pix/COLS] = 1'b1;
                for (int h = 0; h < CH; h++) e_col[h*COLS + pix%COLS] = 1'b1;
            end
            // pen seen through the synchroniser: level driven three clocks before this edge
            hit = 0;
            hp  = -1;
            if (k >= 3) begin
                hp  = (k - 2) % FRAME - ROWS*DC - 1;
                hit = hp >= 0 && hp < ROWS*COLS*PC && hp % PC == PC - 1 && penq[k-3];
            end
            e_hit = hit;
            if (hit) begin
                e_hr = 3'(hp / PC / COLS);
                e_hc = 3'((hp / PC) % COLS);
                for (int h = 0; h < CH; h++) begin
                    if (mode_i == 2'd0) mb[h][hp/PC/COLS][(hp/PC)%COLS] = color_i[h];
                    if (mode_i == 2'd1) mb[h][hp/PC/COLS][(hp/PC)%COLS] = 0;
                end
            end
            if (clr_i) foreach (mb[a, b, c]) mb[a][b][c] = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("row_o", 32'(row_o), 32'(e_row));
            chk("col_o", 32'(col_o), 32'(e_col));
            chk("hit_o", 32'(hit_o), 32'(e_hit));
            chk("hit_row_o", 32'(hit_row_o), 32'(e_hr));
            chk("hit_col_o", 32'(hit_col_o), 32'(e_hc));
            chk("lit_cnt_o", 32'(lit_cnt_o), 32'(e_lit));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        tc++;
        hits += int'(hit_o);
    endtask

    task automatic go(input int t);
        while (tc < t) tick();
    endtask

    function automatic int last_pos(input int n, input int p);
        return FRAME*n + ROWS*DC + 1 + PC*p + PC - 1;
    endfunction

    initial begin
        int n, l;
        logic [6:0] lit0;
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        tc = 0;

        // reset release and DISP/BLANK1 timing
        mode_i  = 2'd0;
        color_i = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rel_row", 32'(row_o), i == 5 ? 32'h02 : 32'h01);
            if (i < 3) chk("rel_nohit", 32'(hit_o), 32'd0);
        end
        go(33);
        chk("blank1_row", 32'(row_o), 32'd0);
        chk("blank1_col", 32'(col_o), 32'd0);

        // single DRAW hit on pixel (3,5)
        go(140);
        hits = 0;
        go(150);
        pen_i = 1'b1;
        go(154);
        pen_i = 1'b0;
        chk("draw_hit", 32'(hit_o), 32'd1);
        chk("draw_hr", 32'(hit_row_o), 32'd3);
        chk("draw_hc", 32'(hit_col_o), 32'd5);
        go(155);
        chk("draw_lit", 32'(lit_cnt_o), 32'd1);
        go(200);
        chk("draw_hits", 32'(hits), 32'd1);
        go(303);
        chk("draw_row3", 32'(row_o), 32'h08);
        chk("draw_col3", 32'(col_o), 32'h0020);

        // ERASE across the whole probe of row 3
        mode_i = 2'd1;
        hits = 0;
        go(420);
        pen_i = 1'b1;
        go(452);
        pen_i = 1'b0;
        go(470);
        chk("erase_hits", 32'(hits), 32'd8);
        chk("erase_lit", 32'(lit_cnt_o), 32'd0);
        go(593);
        chk("erase_col3", 32'(col_o), 32'd0);

        // random traffic
        for (int i = 0; i < 6*FRAME; i++) begin
            tick();
            if ($urandom_range(5) == 0) pen_i = ~pen_i;
            mode_i  = 2'($urandom_range(3));
            color_i = 2'($urandom_range(3));
            clr_i   = ($urandom_range(399) == 0);
        end
        pen_i = 1'b0;
        clr_i = 1'b0;
        mode_i = 2'd0;
        color_i = 2'b11;

        // FREEZE with pen held for an entire frame
        n = tc / FRAME + 1;
        go(FRAME*n + 1);
        mode_i = 2'd2;
        pen_i = 1'b1;
        hits = 0;
        lit0 = lit_cnt_o;
        go(FRAME*n + FRAME + 1);
        pen_i = 1'b0;
        go(FRAME*n + FRAME + 10);
        chk("freeze_hits", 32'(hits), 32'd64);
        chk("freeze_lit", 32'(lit_cnt_o), 32'(lit0));

        // DRAW pixel 3, then clear coinciding with a DRAW write on pixel 10
        mode_i = 2'd0;
        color_i = 2'b11;
        n = tc / FRAME + 1;
        l = last_pos(n, 3);
        go(l - 2);
        pen_i = 1'b1;
        go(l + 2);
        pen_i = 1'b0;
        l = last_pos(n, 10);
        go(l - 2);
        pen_i = 1'b1;
        go(l + 1);
        clr_i = 1'b1;
        go(l + 2);
        pen_i = 1'b0;
        clr_i = 1'b0;
        chk("clr_hit", 32'(hit_o), 32'd1);
        chk("clr_hr", 32'(hit_row_o), 32'd1);
        chk("clr_hc", 32'(hit_col_o), 32'd2);
        go(l + 3);
        chk("clr_lit", 32'(lit_cnt_o), 32'd0);

        // reset in the middle of PROBE with the pen high
        n = tc / FRAME + 1;
        go(FRAME*n + 100);
        pen_i = 1'b1;
        go(FRAME*n + 104);
        rst = 1'b1;
        #1;
        chk("mid_rst_hit", 32'(hit_o), 32'd0);
        chk("mid_rst_row", 32'(row_o), 32'd0);
        chk("mid_rst_col", 32'(col_o), 32'd0);
        tick();
        tick();
        chk("mid_rst_hit2", 32'(hit_o), 32'd0);
        rst = 1'b0;
        tc = 0;
        tick();
        chk("restart_row", 32'(row_o), 32'h01);
        chk("restart_hit", 32'(hit_o), 32'd0);
        tick();
        chk("restart_hit2", 32'(hit_o), 32'd0);
        go(300);
        pen_i = 1'b0;
        go(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
